sys_array_feeder: RTL and testbench

- Transmit-side front end for the systolic mesh.
- Accepts unskewed row vectors over a valid/ready command stream and drives the mesh north and west edges with the required diagonal skew: in_a, in_b, in_d, in_propagate, in_valid and in_dataflow.
- Manages the PE double-buffer bank select. Weight preload into one bank overlaps with compute from the other bank.
- Sits between the scratchpad read path and the mesh edge inputs.

---
 rtl/sys_array_pkg.sv | 31 +++
 rtl/skew_delay.sv | 33 +++
 rtl/sys_array_feeder.sv | 181 ++++++++++++++++++
 tb/tb_sys_array_feeder.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/sys_array_pkg.sv
// Shared types for the systolic-array feeder: FSM states, the stage-0 beat layout
// and the drain length derived from the mesh dimension.
package sys_array_pkg;

   localparam int FEEDER_DIM      = 4;
   localparam int FEEDER_BITWIDTH = 8;
   localparam int ROW_W           = FEEDER_DIM * FEEDER_BITWIDTH;

   typedef enum logic [1:0] {
      IDLE,
      PRELOAD,
      COMPUTE,
      DRAIN
   } feeder_state_e;

   // One unskewed beat as captured at stage 0; data is a whole row vector.
   typedef struct packed {
      logic [ROW_W-1:0] data;
      logic             valid;
      logic             propagate;
      logic             dataflow;
   } lane_beat_t;

   // The skewed tail needs DIM-1 extra cycles to leave the highest lane.
   function automatic int drain_cycles(input int dim);
      return dim - 1;
   endfunction

   localparam int DRAIN_CYCLES = drain_cycles(FEEDER_DIM);

endpackage

// File: rtl/skew_delay.sv
// Fixed-latency shift register used to skew one mesh lane; DEPTH=0 is a plain wire.
module skew_delay #(
   parameter int DEPTH = 0,
   parameter int WIDTH = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] beat,
   output logic [WIDTH-1:0] delayed
);

   generate
      if (DEPTH == 0) begin : g_wire
         logic unused_clocking;
         assign unused_clocking = clock ^ reset;
         assign delayed = beat;
      end else begin : g_shift
         logic [WIDTH-1:0] stage_reg [DEPTH];

         always_ff @(posedge clock) begin
            if (reset) begin
               for (int i = 0; i < DEPTH; i++) stage_reg[i] <= '0;
            end else begin
               stage_reg[0] <= beat;
               for (int i = 1; i < DEPTH; i++) stage_reg[i] <= stage_reg[i-1];
            end
         end

         assign delayed = stage_reg[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/sys_array_feeder.sv
// Mesh edge feeder: accepts unskewed rows, skews them diagonally onto the mesh edges
// and flips the PE bank select per compute batch. Optional bias path: SYS_ARRAY_FEEDER_BIAS_EN.
module sys_array_feeder
   import sys_array_pkg::*;
#(
   parameter int DIM      = FEEDER_DIM,
   parameter int BITWIDTH = FEEDER_BITWIDTH,
   parameter int DATAFLOW = 0
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_preload,
   input  logic                    cmd_last,
   input  logic [DIM*BITWIDTH-1:0] cmd_data,
`ifdef SYS_ARRAY_FEEDER_BIAS_EN
   input  logic [DIM*BITWIDTH-1:0] cmd_bias,
`endif
   output logic [DIM*BITWIDTH-1:0] mesh_a,
   output logic [DIM*BITWIDTH-1:0] mesh_b,
   output logic [DIM*BITWIDTH-1:0] mesh_d,
   output logic [DIM-1:0]          mesh_propagate,
   output logic [DIM-1:0]          mesh_valid,
   output logic [DIM-1:0]          mesh_dataflow,
   output logic                    busy
);

   localparam int CNT_W     = $clog2(DIM) + 1;
   localparam int DRAIN_LEN = drain_cycles(DIM);
   localparam logic [DIM-1:0] HIST_MASK = {DIM{1'b1}} >> 1;
`ifdef SYS_ARRAY_FEEDER_BIAS_EN
   localparam int LANE_W = 3 * BITWIDTH + 2;
`else
   localparam int LANE_W = 2 * BITWIDTH + 2;
`endif

   feeder_state_e    state_reg, state_next;
   logic             bank_reg, bank_next;
   logic [CNT_W-1:0] count_reg, count_next;
   logic             accept;
   logic             is_preload_beat;
   lane_beat_t       beat_reg;
   logic             beat_preload_reg;
   logic [DIM-1:0]   hist_reg;

   assign accept = cmd_valid && cmd_ready;
   // cmd_preload only matters on the first beat; afterwards the state decides.
   assign is_preload_beat = (state_reg == IDLE) ? cmd_preload : (state_reg == PRELOAD);

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg <= IDLE;
         bank_reg  <= 1'b0;
         count_reg <= '0;
      end else begin
         state_reg <= state_next;
         bank_reg  <= bank_next;
         count_reg <= count_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      bank_next  = bank_reg;
      count_next = count_reg;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               if (cmd_preload) begin
                  state_next = (DIM == 1) ? IDLE : PRELOAD;
                  count_next = (DIM == 1) ? '0 : CNT_W'(1);
               end else if (cmd_last) begin
                  bank_next  = ~bank_reg;
                  state_next = (DRAIN_LEN == 0) ? IDLE : DRAIN;
                  count_next = '0;
               end else begin
                  state_next = COMPUTE;
               end
            end
         end
         PRELOAD: begin
            if (accept) begin
               if (count_reg == CNT_W'(DIM - 1)) begin
                  state_next = IDLE;
                  count_next = '0;
               end else begin
                  count_next = count_reg + CNT_W'(1);
               end
            end
         end
         COMPUTE: begin
            if (accept && cmd_last) begin
               bank_next  = ~bank_reg;
               state_next = (DRAIN_LEN == 0) ? IDLE : DRAIN;
               count_next = '0;
            end
         end
         DRAIN: begin
            if (count_reg == CNT_W'(DRAIN_LEN - 1)) begin
               state_next = IDLE;
               count_next = '0;
            end else begin
               count_next = count_reg + CNT_W'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      cmd_ready = (state_reg != DRAIN);
      busy      = (state_reg != IDLE) || beat_reg.valid || (|(hist_reg & HIST_MASK));
   end

   // Stage 0: bubbles zero the data but keep the last propagate so lanes never glitch it.
   always_ff @(posedge clock) begin
      if (reset) begin
         beat_reg         <= '{data: '0, valid: 1'b0, propagate: 1'b0, dataflow: DATAFLOW[0]};
         beat_preload_reg <= 1'b0;
         hist_reg         <= '0;
      end else begin
         beat_reg.valid     <= accept;
         beat_reg.data      <= accept ? cmd_data : '0;
         beat_reg.propagate <= accept ? (is_preload_beat ? bank_reg : ~bank_reg)
                                      : beat_reg.propagate;
         beat_reg.dataflow  <= DATAFLOW[0];
         beat_preload_reg   <= accept && is_preload_beat;
         hist_reg           <= (hist_reg << 1) | DIM'(beat_reg.valid);
      end
   end

`ifdef SYS_ARRAY_FEEDER_BIAS_EN
   logic [DIM*BITWIDTH-1:0] bias_reg;

   always_ff @(posedge clock) begin
      if (reset) bias_reg <= '0;
      else       bias_reg <= (accept && !is_preload_beat) ? cmd_bias : '0;
   end
`endif

   genvar gi;
   generate
      for (gi = 0; gi < DIM; gi++) begin : g_lane
         logic [BITWIDTH-1:0] lane_data;
         logic [LANE_W-1:0]   lane_in;
         logic [LANE_W-1:0]   lane_out;

         assign lane_data = beat_reg.data[gi*BITWIDTH +: BITWIDTH];
`ifdef SYS_ARRAY_FEEDER_BIAS_EN
         assign lane_in = {beat_preload_reg ? BITWIDTH'(0) : lane_data,
                           beat_preload_reg ? lane_data : BITWIDTH'(0),
                           bias_reg[gi*BITWIDTH +: BITWIDTH],
                           beat_reg.valid, beat_reg.propagate};
         assign mesh_d[gi*BITWIDTH +: BITWIDTH] = lane_out[2 +: BITWIDTH];
`else
         assign lane_in = {beat_preload_reg ? BITWIDTH'(0) : lane_data,
                           beat_preload_reg ? lane_data : BITWIDTH'(0),
                           beat_reg.valid, beat_reg.propagate};
         assign mesh_d[gi*BITWIDTH +: BITWIDTH] = '0;
`endif

         skew_delay #(
            .DEPTH (gi),
            .WIDTH (LANE_W)
         ) u_skew (
            .clock   (clock),
            .reset   (reset),
            .beat    (lane_in),
            .delayed (lane_out)
         );

         assign mesh_a[gi*BITWIDTH +: BITWIDTH] = lane_out[LANE_W-1 -: BITWIDTH];
         assign mesh_b[gi*BITWIDTH +: BITWIDTH] = lane_out[LANE_W-1-BITWIDTH -: BITWIDTH];
         assign mesh_valid[gi]     = lane_out[1];
         assign mesh_propagate[gi] = lane_out[0];
         assign mesh_dataflow[gi]  = beat_reg.dataflow;
      end
   endgenerate

endmodule

// File: tb/tb_sys_array_feeder.sv
// Directed bench for sys_array_feeder: preload, compute, drain, bubbles, overlap and
// mid-batch reset; mesh outputs are logged per cycle and compared against hand values.
module tb_sys_array_feeder;
   import sys_array_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_preload = 1'b0;
   logic        cmd_last = 1'b0;
   logic [31:0] cmd_data = '0;
   logic [31:0] cmd_bias = '0;
   logic [31:0] mesh_a, mesh_b, mesh_d;
   logic [3:0]  mesh_propagate, mesh_valid, mesh_dataflow;
   logic        busy;

`ifdef SYS_ARRAY_FEEDER_BIAS_EN
   localparam bit BIAS_ON = 1'b1;
`else
   localparam bit BIAS_ON = 1'b0;
`endif

   sys_array_feeder #(
      .DIM      (4),
      .BITWIDTH (8),
      .DATAFLOW (0)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_preload    (cmd_preload),
      .cmd_last       (cmd_last),
      .cmd_data       (cmd_data),
`ifdef SYS_ARRAY_FEEDER_BIAS_EN
      .cmd_bias       (cmd_bias),
`endif
      .mesh_a         (mesh_a),
      .mesh_b         (mesh_b),
      .mesh_d         (mesh_d),
      .mesh_propagate (mesh_propagate),
      .mesh_valid     (mesh_valid),
      .mesh_dataflow  (mesh_dataflow),
      .busy           (busy)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   logic [31:0] lg_a [128];
   logic [31:0] lg_b [128];
   logic [31:0] lg_d [128];
   logic [3:0]  lg_v [128];
   logic [3:0]  lg_p [128];
   logic        lg_ready [128];
   logic        lg_busy [128];

   always @(negedge clock) begin
      if (cyc < 128) begin
         lg_a[cyc]     <= mesh_a;
         lg_b[cyc]     <= mesh_b;
         lg_d[cyc]     <= mesh_d;
         lg_v[cyc]     <= mesh_valid;
         lg_p[cyc]     <= mesh_propagate;
         lg_ready[cyc] <= cmd_ready;
         lg_busy[cyc]  <= busy;
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] row(input logic [7:0] base);
      return {base + 8'd3, base + 8'd2, base + 8'd1, base};
   endfunction

   function automatic logic [31:0] lane(input logic [31:0] v, input int k);
      return {24'd0, v[k*8 +: 8]};
   endfunction

   task automatic beat(input logic v, input logic pre, input logic last,
                       input logic [31:0] data, input logic [31:0] bias);
      cmd_valid   = v;
      cmd_preload = pre;
      cmd_last    = last;
      cmd_data    = data;
      cmd_bias    = bias;
      #1;
      if (v && cmd_ready && !reset)
         $display("cycle %0d: beat preload=%0b last=%0b data=%h bias=%h", cyc, pre, last, data, bias);
      @(posedge clock);
      #1;
   endtask

   int p0;
   int q0;

   initial begin
      repeat (3) @(posedge clock);
      #1;
      check("rst_valid", 32'(mesh_valid), 32'd0);
      check("rst_a", mesh_a, 32'd0);
      check("rst_b", mesh_b, 32'd0);
      check("rst_d", mesh_d, 32'd0);
      check("rst_prop", 32'(mesh_propagate), 32'd0);
      check("rst_dataflow", 32'(mesh_dataflow), 32'd0);
      check("rst_ready", 32'(cmd_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);

      reset = 1'b0;
      p0 = cyc;
      // Preload 4 rows, then compute 3 rows back to back.
      for (int r = 0; r < 4; r++) beat(1'b1, 1'b1, 1'b0, row(8'(4*r + 1)), row(8'h90));
      for (int r = 0; r < 3; r++) beat(1'b1, 1'b0, (r == 2), row(8'(8'h20 + 4*r)),
                                       (r == 0) ? row(8'd5) : 32'd0);
      // Preload held during DRAIN: only taken once ready returns.
      for (int i = 0; i < 4; i++) beat(1'b1, 1'b1, 1'b0, row(8'h40), 32'd0);
      for (int r = 1; r < 4; r++) beat(1'b1, 1'b1, 1'b0, row(8'(8'h40 + 4*r)), 32'd0);
      // Compute with a bubble.
      beat(1'b1, 1'b0, 1'b0, row(8'h60), 32'd0);
      beat(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      beat(1'b1, 1'b0, 1'b1, row(8'h64), 32'd0);
      repeat (8) beat(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      // Single-beat compute straight from IDLE, flips the bank to 1.
      beat(1'b1, 1'b0, 1'b1, row(8'hB0), 32'd0);
      repeat (3) beat(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

      q0 = cyc;
      beat(1'b1, 1'b1, 1'b0, row(8'hA0), 32'd0);
      reset = 1'b1;
      beat(1'b1, 1'b1, 1'b0, row(8'hA4), 32'd0);
      check("midrst_valid", 32'(mesh_valid), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_bank", 32'(dut.bank_reg), 32'd0);
      check("midrst_ready", 32'(cmd_ready), 32'd1);
      check("midrst_state", 32'(dut.state_reg), 32'(IDLE));
      reset = 1'b0;
      beat(1'b1, 1'b1, 1'b0, row(8'hC0), 32'd0);
      check("postrst_valid0", 32'(mesh_valid[0]), 32'd1);
      check("postrst_prop0", 32'(mesh_propagate[0]), 32'd0);
      check("postrst_b0", lane(mesh_b, 0), 32'hC0);
      repeat (4) beat(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

      for (int k = 0; k < 4; k++) check("pre_idle_valid", 32'(lg_v[p0 + k][k]), 32'd0);

      for (int r = 0; r < 4; r++) begin
         for (int k = 0; k < 4; k++) begin
            check("pre_b", lane(lg_b[p0 + 1 + r + k], k), 32'(4*r + k + 1));
            check("pre_a", lane(lg_a[p0 + 1 + r + k], k), 32'd0);
            check("pre_d", lane(lg_d[p0 + 1 + r + k], k), 32'd0);
            check("pre_valid", 32'(lg_v[p0 + 1 + r + k][k]), 32'd1);
            check("pre_prop", 32'(lg_p[p0 + 1 + r + k][k]), 32'd0);
         end
      end

      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < 4; k++) begin
            check("cmp_a", lane(lg_a[p0 + 5 + r + k], k), 32'(8'h20 + 4*r + k));
            check("cmp_b", lane(lg_b[p0 + 5 + r + k], k), 32'd0);
            check("cmp_valid", 32'(lg_v[p0 + 5 + r + k][k]), 32'd1);
            check("cmp_prop", 32'(lg_p[p0 + 5 + r + k][k]), 32'd1);
         end
      end
      for (int k = 0; k < 4; k++)
         check("cmp_bias", lane(lg_d[p0 + 5 + k], k), BIAS_ON ? 32'(5 + k) : 32'd0);

      check("ready_last", 32'(lg_ready[p0 + 6]), 32'd1);
      for (int i = 7; i < 10; i++) check("ready_drain", 32'(lg_ready[p0 + i]), 32'd0);
      check("ready_after", 32'(lg_ready[p0 + 10]), 32'd1);

      for (int r = 0; r < 4; r++) begin
         for (int k = 0; k < 4; k++) begin
            check("pre2_b", lane(lg_b[p0 + 11 + r + k], k), 32'(8'h40 + 4*r + k));
            check("pre2_prop", 32'(lg_p[p0 + 11 + r + k][k]), 32'd1);
         end
      end

      check("bub_v0", 32'(lg_v[p0 + 17][2]), 32'd1);
      check("bub_v1", 32'(lg_v[p0 + 18][2]), 32'd0);
      check("bub_v2", 32'(lg_v[p0 + 19][2]), 32'd1);
      check("bub_a0", lane(lg_a[p0 + 17], 2), 32'h62);
      check("bub_a1", lane(lg_a[p0 + 18], 2), 32'h00);
      check("bub_a2", lane(lg_a[p0 + 19], 2), 32'h66);
      for (int i = 17; i < 20; i++) check("bub_prop", 32'(lg_p[p0 + i][2]), 32'd0);

      check("busy_tail", 32'(lg_busy[p0 + 20]), 32'd1);
      check("busy_done", 32'(lg_busy[p0 + 21]), 32'd0);
      check("idle_last_drain", 32'(lg_ready[p0 + 26]), 32'd0);
      check("reset_test_start", 32'(q0 - p0), 32'd29);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
